// File: rtl/rx_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet becomes readable only once its
// tlast beat is written, and a packet that cannot fit is dropped whole.
module rx_pkt_fifo #(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int PTR_W  = ADDR_W + 1
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_tvalid,
    input  logic [511:0]      s_axis_tdata,
    input  logic [63:0]       s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [47:0]       s_axis_tuser,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [511:0]      m_axis_tdata,
    output logic [63:0]       m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [47:0]       m_axis_tuser,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   fill_level,
    output logic [31:0]       pkt_in_count,
    output logic [31:0]       pkt_out_count,
    output logic [31:0]       drop_count
);

    localparam int ENTRY_W = 48 + 1 + 64 + 512;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DISCARD
    } wr_state_t;

    wr_state_t          state_q;
    wr_state_t          state_d;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_commit;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   occ;
    logic               full;

    logic               accept_p0;
    logic               wr_en;
    logic               commit;
    logic               rewind;
    logic               drop_inc;

    logic               rd_en;
    logic               pop;
    logic [ENTRY_W-1:0] entry_p1;
    logic               vld_p1;

    // Input stage: accepted beat, write decision
    assign accept_p0 = s_axis_tvalid && s_axis_tready;

    // Occupancy includes the beat held in the output register, so the FIFO
    // never owns more than DEPTH beats and fill_level reports all of them.
    assign occ        = (wr_ptr - rd_ptr) + PTR_W'(vld_p1);
    assign full       = (occ == PTR_W'(DEPTH));
    assign fill_level = occ;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        drop_inc = 1'b0;
        if (accept_p0) begin
            case (state_q)
                IDLE, WRITE: begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        commit  = s_axis_tlast;
                        state_d = s_axis_tlast ? IDLE : WRITE;
                    end else begin
                        rewind   = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = s_axis_tlast ? IDLE : DISCARD;
                    end
                end
                DISCARD: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr        <= '0;
            wr_commit     <= '0;
            pkt_in_count  <= '0;
            drop_count    <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            if (rewind) begin
                wr_ptr <= wr_commit;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (commit) begin
                wr_commit    <= wr_ptr + PTR_W'(1);
                pkt_in_count <= pkt_in_count + 32'd1;
            end
            if (drop_inc) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Output stage: synchronous memory read straight into the m_axis register
    assign rd_en = (rd_ptr != wr_commit) && (!vld_p1 || m_axis_tready);
    assign pop   = vld_p1 && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (rd_en) begin
            entry_p1 <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_ptr        <= '0;
            vld_p1        <= 1'b0;
            pkt_out_count <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                vld_p1 <= 1'b1;
            end else if (m_axis_tready) begin
                vld_p1 <= 1'b0;
            end
            if (pop && m_axis_tlast) begin
                pkt_out_count <= pkt_out_count + 32'd1;
            end
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = entry_p1;

endmodule
